// File: rtl/mcp_pkg.sv
// Shared widths and slot-owner encoding for the MicROM port arbiter.
package mcp_pkg;
   localparam int MC_AW = 11;
   localparam int MC_DW = 22;

   typedef enum logic [1:0] {
      MC_OWN_NONE = 2'd0,
      MC_OWN_CPU  = 2'd1,
      MC_OWN_DBG  = 2'd2
   } mc_own_e;
endpackage

// File: rtl/mcp_arb_starve.sv
// Saturating count of debug-denied cycles; at_max forces the next slot to debug.
module mcp_arb_starve
   import mcp_pkg::*;
#(
   parameter int STARVE_MAX = 8
) (
   input  logic pin_clk,
   input  logic pin_rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [3:0] cnt;

   always_ff @(posedge pin_clk) begin
      if (!pin_rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt < 4'(STARVE_MAX))) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign at_max = (cnt >= 4'(STARVE_MAX));

endmodule

// File: rtl/mcp_arb.sv
// Shares the MicROM read port between the microsequencer and a debug host,
// tracking slot ownership one cycle behind the issued address.
module mcp_arb
   import mcp_pkg::*;
#(
   parameter int STARVE_MAX = 8
) (
   input  logic             pin_clk,
   input  logic             pin_rst_n,
   input  logic             cpu_req,
   input  logic [MC_AW-1:0] cpu_lc,
   output logic             cpu_wait,
   output logic [MC_DW-1:0] cpu_mo,
   output logic             cpu_vld,
   input  logic             dbg_req,
   input  logic [MC_AW-1:0] dbg_adr,
   output logic             dbg_ack,
   output logic [MC_DW-1:0] dbg_dat,
   output logic             dbg_rdy,
   output logic [MC_AW-1:0] rom_lc,
   input  logic [MC_DW-1:0] rom_mo
);

   mc_own_e          grant;
   mc_own_e          owner_q;
   logic             dbg_busy;
   logic             starve_max;
   logic [MC_AW-1:0] lc_hold;

   mcp_arb_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .pin_clk   (pin_clk),
      .pin_rst_n (pin_rst_n),
      .inc       (dbg_req && !dbg_busy && (grant == MC_OWN_CPU)),
      .clr       ((grant == MC_OWN_DBG) || !dbg_req),
      .at_max    (starve_max)
   );

   // Grant is forced to NONE in reset so wait/ack stay low.
   always_comb begin
      grant = MC_OWN_NONE;
      if (pin_rst_n) begin
         if (dbg_req && !dbg_busy && (!cpu_req || starve_max)) begin
            grant = MC_OWN_DBG;
         end else if (cpu_req) begin
            grant = MC_OWN_CPU;
         end
      end
   end

   always_comb begin
      rom_lc = lc_hold;
      case (grant)
         MC_OWN_CPU: rom_lc = cpu_lc;
         MC_OWN_DBG: rom_lc = dbg_adr;
         default:    rom_lc = lc_hold;
      endcase
   end

   assign cpu_wait = cpu_req && (grant == MC_OWN_DBG);
   assign dbg_ack  = (grant == MC_OWN_DBG);
   assign cpu_mo   = rom_mo;

   // Issue stage -> return stage: rom_mo belongs to owner_q.
   always_ff @(posedge pin_clk) begin
      if (!pin_rst_n) begin
         owner_q  <= MC_OWN_NONE;
         cpu_vld  <= 1'b0;
         dbg_rdy  <= 1'b0;
         dbg_dat  <= '0;
         lc_hold  <= '0;
         dbg_busy <= 1'b0;
      end else begin
         owner_q <= grant;
         cpu_vld <= (grant == MC_OWN_CPU);
         dbg_rdy <= (owner_q == MC_OWN_DBG);
         if (owner_q == MC_OWN_DBG) begin
            dbg_dat <= rom_mo;
         end
         if (grant != MC_OWN_NONE) begin
            lc_hold <= rom_lc;
         end
         if (grant == MC_OWN_DBG) begin
            dbg_busy <= 1'b1;
         end else if (owner_q == MC_OWN_DBG) begin
            dbg_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mcp_arb.sv
// Bench for mcp_arb: directed vector table, then random traffic against a slot-queue model.
module tb_mcp_arb;

   localparam int SM = 3;

   logic        pin_clk;
   logic        pin_rst_n;
   logic        cpu_req;
   logic [10:0] cpu_lc;
   logic        cpu_wait;
   logic [21:0] cpu_mo;
   logic        cpu_vld;
   logic        dbg_req;
   logic [10:0] dbg_adr;
   logic        dbg_ack;
   logic [21:0] dbg_dat;
   logic        dbg_rdy;
   logic [10:0] rom_lc;
   logic [21:0] rom_mo;
   logic [21:0] rom_q;

   int tests = 0;
   int fails = 0;

   mcp_arb #(.STARVE_MAX(SM)) dut (
      .pin_clk   (pin_clk),
      .pin_rst_n (pin_rst_n),
      .cpu_req   (cpu_req),
      .cpu_lc    (cpu_lc),
      .cpu_wait  (cpu_wait),
      .cpu_mo    (cpu_mo),
      .cpu_vld   (cpu_vld),
      .dbg_req   (dbg_req),
      .dbg_adr   (dbg_adr),
      .dbg_ack   (dbg_ack),
      .dbg_dat   (dbg_dat),
      .dbg_rdy   (dbg_rdy),
      .rom_lc    (rom_lc),
      .rom_mo    (rom_mo)
   );

   initial pin_clk = 1'b0;
   always #5 pin_clk = ~pin_clk;

   function automatic logic [21:0] rom_fn(input logic [10:0] a);
      logic [3:0] m;
      case (a)
         11'h022: m = 4'hC;
         11'h1C2: m = 4'hF;
         default: m = a[3:0] ^ a[10:7];
      endcase
      return {m, a[6:0] ^ 7'h55, a};
   endfunction

   // Stand-in MicROM with one-cycle registered read.
   always @(posedge pin_clk) rom_q <= rom_fn(rom_lc);
   assign rom_mo = rom_q;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   typedef struct {
      bit          rst_n;
      bit          creq;
      logic [10:0] clc;
      bit          dreq;
      logic [10:0] dadr;
      bit          wt;
      bit          ack;
      logic [10:0] lc;
      bit          cvld;
      logic [21:0] cmo;
      bit          drdy;
      logic [21:0] ddat;
   } vec_t;

   function automatic vec_t mk(bit r, bit cq, logic [10:0] cl, bit dq, logic [10:0] da,
                               bit w, bit a, logic [10:0] l, bit cv, logic [21:0] cm,
                               bit dr, logic [21:0] dd);
      vec_t v;
      v.rst_n = r; v.creq = cq; v.clc = cl; v.dreq = dq; v.dadr = da;
      v.wt = w; v.ack = a; v.lc = l; v.cvld = cv; v.cmo = cm; v.drdy = dr; v.ddat = dd;
      return v;
   endfunction

   typedef struct {
      int          due;
      bit          is_dbg;
      logic [10:0] addr;
   } slot_t;

   vec_t  tbl[29];
   slot_t q[$];
   slot_t keep[$];

   initial begin
      logic [21:0] r022, r023, r024, r1c2, r100, r101, r102, r103, r104, r200, r0f0;
      int          m_cnt;
      int          dbg_free_at;
      logic [10:0] m_hold;
      logic [21:0] m_ddat;
      bit          prev_ack, prev_wait, busy, e_cvld, e_drdy;
      logic [21:0] e_cmo;
      logic [10:0] e_lc;
      int          g;

      r022 = rom_fn(11'h022); r023 = rom_fn(11'h023); r024 = rom_fn(11'h024);
      r1c2 = rom_fn(11'h1C2); r100 = rom_fn(11'h100); r101 = rom_fn(11'h101);
      r102 = rom_fn(11'h102); r103 = rom_fn(11'h103); r104 = rom_fn(11'h104);
      r200 = rom_fn(11'h200); r0f0 = rom_fn(11'h0F0);

      tbl[0]  = mk(0,1,11'h022,1,11'h1C2, 0,0,11'h000, 0,0,    0,0);
      tbl[1]  = mk(1,1,11'h022,0,11'h000, 0,0,11'h022, 0,0,    0,0);
      tbl[2]  = mk(1,1,11'h023,0,11'h000, 0,0,11'h023, 1,r022, 0,0);
      tbl[3]  = mk(1,1,11'h024,0,11'h000, 0,0,11'h024, 1,r023, 0,0);
      tbl[4]  = mk(1,0,11'h000,0,11'h000, 0,0,11'h024, 1,r024, 0,0);
      tbl[5]  = mk(1,0,11'h000,0,11'h000, 0,0,11'h024, 0,0,    0,0);
      tbl[6]  = mk(1,0,11'h000,1,11'h1C2, 0,1,11'h1C2, 0,0,    0,0);
      tbl[7]  = mk(1,0,11'h000,0,11'h000, 0,0,11'h1C2, 0,0,    0,0);
      tbl[8]  = mk(1,0,11'h000,0,11'h000, 0,0,11'h1C2, 0,0,    1,r1c2);
      tbl[9]  = mk(1,0,11'h000,0,11'h000, 0,0,11'h1C2, 0,0,    0,r1c2);
      tbl[10] = mk(1,1,11'h100,1,11'h200, 0,0,11'h100, 0,0,    0,r1c2);
      tbl[11] = mk(1,1,11'h101,1,11'h200, 0,0,11'h101, 1,r100, 0,r1c2);
      tbl[12] = mk(1,1,11'h102,1,11'h200, 0,0,11'h102, 1,r101, 0,r1c2);
      tbl[13] = mk(1,1,11'h103,1,11'h200, 1,1,11'h200, 1,r102, 0,r1c2);
      tbl[14] = mk(1,1,11'h103,0,11'h200, 0,0,11'h103, 0,0,    0,r1c2);
      tbl[15] = mk(1,1,11'h104,0,11'h000, 0,0,11'h104, 1,r103, 1,r200);
      tbl[16] = mk(1,0,11'h000,0,11'h000, 0,0,11'h104, 1,r104, 0,r200);
      tbl[17] = mk(1,0,11'h000,1,11'h0F0, 0,1,11'h0F0, 0,0,    0,r200);
      tbl[18] = mk(1,0,11'h000,1,11'h0F0, 0,0,11'h0F0, 0,0,    0,r200);
      tbl[19] = mk(1,0,11'h000,1,11'h0F0, 0,1,11'h0F0, 0,0,    1,r0f0);
      tbl[20] = mk(1,0,11'h000,1,11'h0F0, 0,0,11'h0F0, 0,0,    0,r0f0);
      tbl[21] = mk(1,0,11'h000,1,11'h0F0, 0,1,11'h0F0, 0,0,    1,r0f0);
      tbl[22] = mk(1,0,11'h000,1,11'h0F0, 0,0,11'h0F0, 0,0,    0,r0f0);
      tbl[23] = mk(1,0,11'h000,0,11'h000, 0,0,11'h0F0, 0,0,    1,r0f0);
      tbl[24] = mk(1,0,11'h000,0,11'h000, 0,0,11'h0F0, 0,0,    0,r0f0);
      tbl[25] = mk(1,0,11'h000,1,11'h333, 0,1,11'h333, 0,0,    0,r0f0);
      tbl[26] = mk(0,1,11'h7FF,1,11'h333, 0,0,11'h333, 0,0,    0,r0f0);
      tbl[27] = mk(1,0,11'h000,0,11'h000, 0,0,11'h000, 0,0,    0,0);
      tbl[28] = mk(1,0,11'h000,0,11'h000, 0,0,11'h000, 0,0,    0,0);

      pin_rst_n = 1'b0; cpu_req = 1'b0; cpu_lc = '0; dbg_req = 1'b0; dbg_adr = '0;
      repeat (2) @(posedge pin_clk);

      for (int i = 0; i < 29; i++) begin
         @(posedge pin_clk); #1;
         pin_rst_n = tbl[i].rst_n;
         cpu_req   = tbl[i].creq;
         cpu_lc    = tbl[i].clc;
         dbg_req   = tbl[i].dreq;
         dbg_adr   = tbl[i].dadr;
         @(negedge pin_clk);
         chk("vec_cpu_wait", i, 32'(cpu_wait), 32'(tbl[i].wt));
         chk("vec_dbg_ack",  i, 32'(dbg_ack),  32'(tbl[i].ack));
         chk("vec_rom_lc",   i, 32'(rom_lc),   32'(tbl[i].lc));
         chk("vec_cpu_vld",  i, 32'(cpu_vld),  32'(tbl[i].cvld));
         if (tbl[i].cvld) chk("vec_cpu_mo", i, 32'(cpu_mo), 32'(tbl[i].cmo));
         chk("vec_dbg_rdy",  i, 32'(dbg_rdy),  32'(tbl[i].drdy));
         chk("vec_dbg_dat",  i, 32'(dbg_dat),  32'(tbl[i].ddat));
      end

      // Random traffic: the model tracks granted slots as a queue of due cycles.
      m_cnt = 0; dbg_free_at = 0; m_hold = '0; m_ddat = '0;
      prev_ack = 0; prev_wait = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge pin_clk); #1;
         pin_rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
         if (!prev_wait) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_lc  = 11'($urandom);
         end
         dbg_req = prev_ack ? 1'b0 : 1'($urandom_range(0, 1));
         dbg_adr = 11'($urandom);

         busy = (c < dbg_free_at);
         if (!pin_rst_n) g = 0;
         else if (dbg_req && !busy && (!cpu_req || m_cnt == SM)) g = 2;
         else if (cpu_req) g = 1;
         else g = 0;
         e_lc = (g == 1) ? cpu_lc : (g == 2) ? dbg_adr : m_hold;

         e_cvld = 0; e_drdy = 0; e_cmo = '0;
         keep.delete();
         foreach (q[k]) begin
            if (q[k].due == c) begin
               if (q[k].is_dbg) begin
                  e_drdy = 1; m_ddat = rom_fn(q[k].addr);
               end else begin
                  e_cvld = 1; e_cmo = rom_fn(q[k].addr);
               end
            end else if (q[k].due > c) begin
               keep.push_back(q[k]);
            end
         end
         q = keep;

         @(negedge pin_clk);
         chk("rnd_cpu_wait", c, 32'(cpu_wait), 32'(cpu_req && g == 2));
         chk("rnd_dbg_ack",  c, 32'(dbg_ack),  32'(g == 2));
         chk("rnd_rom_lc",   c, 32'(rom_lc),   32'(e_lc));
         chk("rnd_cpu_vld",  c, 32'(cpu_vld),  32'(e_cvld));
         if (e_cvld) chk("rnd_cpu_mo", c, 32'(cpu_mo), 32'(e_cmo));
         chk("rnd_dbg_rdy",  c, 32'(dbg_rdy),  32'(e_drdy));
         chk("rnd_dbg_dat",  c, 32'(dbg_dat),  32'(m_ddat));

         if (!pin_rst_n) begin
            q.delete();
            m_cnt = 0; dbg_free_at = 0; m_hold = '0; m_ddat = '0;
         end else begin
            if (g == 1) q.push_back('{c + 1, 1'b0, cpu_lc});
            if (g == 2) begin
               q.push_back('{c + 2, 1'b1, dbg_adr});
               dbg_free_at = c + 2;
            end
            if (g != 0) m_hold = e_lc;
            if (g == 2 || !dbg_req) m_cnt = 0;
            else if (!busy && g == 1 && m_cnt < SM) m_cnt++;
         end
         prev_ack  = (g == 2);
         prev_wait = cpu_req && (g == 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
